// File: rtl/alu_pkg.sv
// Shared types for the ALU request sequencer: op codes, flag/request payloads, sequencer states.
package alu_pkg;

    typedef enum logic [2:0] {
        AND  = 3'd0,
        ADD  = 3'd1,
        SUB  = 3'd2,
        SLT  = 3'd3,
        SRL  = 3'd4,
        SRA  = 3'd5,
        SLL  = 3'd6,
        RSVD = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic overflow;
        logic equal;
        logic zero;
    } alu_flags_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        alu_op_t     op;
    } alu_req_t;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE = 2'd0;
    localparam seq_state_t ST_WAIT = 2'd1;
    localparam seq_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO for the ALU sequencer; count-based full/empty, pointers wrap modulo DEPTH.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     n_rst,
    input  logic     push,
    input  alu_req_t push_data,
    input  logic     pop,
    output alu_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    alu_req_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/alu_req_seq.sv
// Initiator side of the ALU operand/result interface: queue requests, hold operands, capture results.
// Optional macro ALU_REQ_STATS_EN adds stat_ops / stat_ovf response counters.
module alu_req_seq
    import alu_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [2:0]  req_op,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_z,
    input  logic        alu_zero,
    input  logic        alu_equal,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err,
`ifdef ALU_REQ_STATS_EN
    output logic [31:0] stat_ops,
    output logic [31:0] stat_ovf,
`endif
    output logic        busy
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    seq_state_t  state;
    logic [3:0]  cnt;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    alu_req_t    push_data;
    alu_req_t    head;
    alu_flags_t  cap_flags;

    assign push      = req_valid && !full;
    assign req_ready = !full;
    assign push_data = '{x: req_x, y: req_y, op: alu_op_t'(req_op)};
    // Pop from IDLE, or straight out of RESP on the handshake for back-to-back issue.
    assign pop       = !empty && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
    assign cap_flags = '{overflow: alu_overflow, equal: alu_equal, zero: alu_zero};

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_op    <= '0;
            rsp_z     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (pop) begin
                alu_x  <= head.x;
                alu_y  <= head.y;
                alu_op <= head.op;
                cnt    <= CNT_INIT;
            end
            case (state)
                ST_IDLE: begin
                    if (!empty) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rsp_z     <= alu_z;
                        rsp_flags <= cap_flags;
                        rsp_err   <= (alu_op == RSVD);
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) state <= empty ? ST_IDLE : ST_WAIT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_REQ_STATS_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if ((state == ST_RESP) && rsp_ready) begin
            stat_ops <= stat_ops + 32'd1;
            if (rsp_flags[2]) stat_ovf <= stat_ovf + 32'd1;
        end
    end
`endif

    assign rsp_valid = (state == ST_RESP);
    assign busy      = !empty || (state != ST_IDLE);

endmodule

// File: tb/tb_alu_req_seq.sv
// Directed self-checking bench for alu_req_seq: instance A settles 1 cycle, instance B settles 3.
module tb_alu_req_seq;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;

    logic        a_req_valid = 1'b0, a_req_ready, a_rsp_valid, a_rsp_ready = 1'b1, a_rsp_err, a_busy;
    logic [31:0] a_req_x = '0, a_req_y = '0, a_alu_x, a_alu_y, a_alu_z, a_rsp_z;
    logic [2:0]  a_req_op = '0, a_alu_op, a_rsp_flags;
    logic        a_alu_zero, a_alu_equal, a_alu_overflow;

    logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_ready = 1'b1, b_rsp_err, b_busy;
    logic [31:0] b_req_x = '0, b_req_y = '0, b_alu_x, b_alu_y, b_alu_z, b_rsp_z;
    logic [2:0]  b_req_op = '0, b_alu_op, b_rsp_flags;
    logic        b_alu_zero, b_alu_equal, b_alu_overflow;
`ifdef ALU_REQ_STATS_EN
    logic [31:0] a_stat_ops, a_stat_ovf, b_stat_ops, b_stat_ovf;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Reference ALU: returns {overflow, equal, zero, z}; reserved op returns all zero.
    function automatic logic [34:0] alu_model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        logic [31:0] z;
        logic        ovf;
        z   = '0;
        ovf = 1'b0;
        case (op)
            3'd0: z = x & y;
            3'd1: begin z = x + y; ovf = (x[31] == y[31]) && (z[31] != x[31]); end
            3'd2: begin z = x - y; ovf = (x[31] != y[31]) && (z[31] != x[31]); end
            3'd3: z = {31'b0, ($signed(x) < $signed(y))};
            3'd4: z = x >> y[4:0];
            3'd5: z = $signed(x) >>> y[4:0];
            3'd6: z = x << y[4:0];
            default: z = '0;
        endcase
        if (op == 3'd7) return 35'b0;
        return {ovf, (x == y), (z == 32'd0), z};
    endfunction

    assign {a_alu_overflow, a_alu_equal, a_alu_zero, a_alu_z} = alu_model(a_alu_x, a_alu_y, a_alu_op);
    assign {b_alu_overflow, b_alu_equal, b_alu_zero, b_alu_z} = alu_model(b_alu_x, b_alu_y, b_alu_op);

    alu_req_seq #(.DEPTH(4), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .n_rst(n_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_x(a_req_x), .req_y(a_req_y), .req_op(a_req_op),
        .alu_x(a_alu_x), .alu_y(a_alu_y), .alu_op(a_alu_op),
        .alu_z(a_alu_z), .alu_zero(a_alu_zero), .alu_equal(a_alu_equal), .alu_overflow(a_alu_overflow),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_z(a_rsp_z), .rsp_flags(a_rsp_flags), .rsp_err(a_rsp_err),
`ifdef ALU_REQ_STATS_EN
        .stat_ops(a_stat_ops), .stat_ovf(a_stat_ovf),
`endif
        .busy(a_busy)
    );

    alu_req_seq #(.DEPTH(4), .SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .n_rst(n_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_x(b_req_x), .req_y(b_req_y), .req_op(b_req_op),
        .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_op(b_alu_op),
        .alu_z(b_alu_z), .alu_zero(b_alu_zero), .alu_equal(b_alu_equal), .alu_overflow(b_alu_overflow),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_z(b_rsp_z), .rsp_flags(b_rsp_flags), .rsp_err(b_rsp_err),
`ifdef ALU_REQ_STATS_EN
        .stat_ops(b_stat_ops), .stat_ovf(b_stat_ovf),
`endif
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        a_req_x = x; a_req_y = y; a_req_op = op; a_req_valid = 1'b1;
        step();
        a_req_valid = 1'b0;
    endtask

    // Waits (bounded) for a response on A and checks its payload; caller consumes it.
    task automatic expect_rsp_a(input string tag, input logic [31:0] z, input logic [2:0] flags, input logic err);
        int n;
        n = 0;
        while (a_rsp_valid !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 64'(a_rsp_valid), 64'd1);
        chk({tag, "_z"}, 64'(a_rsp_z), 64'(z));
        chk({tag, "_flags_err"}, 64'({a_rsp_flags, a_rsp_err}), 64'({flags, err}));
    endtask

    logic [31:0] fx [6] = '{32'hF0F0F0F0, 32'hFFFFFFFF, 32'h00000008, 32'h80000000, 32'h00000001, 32'h00000001};
    logic [31:0] fy [6] = '{32'hFF00FF00, 32'h00000001, 32'h00000004, 32'h00000004, 32'h0000001F, 32'h00000001};
    logic [2:0]  fop[6] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    logic [31:0] fz [5] = '{32'hF000F000, 32'h00000001, 32'h00000000, 32'hF8000000, 32'h80000000};
    logic [2:0]  ffl[5] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000};

    initial begin
        logic seen;

        #1 n_rst = 1'b0;
        #1;
        chk("rst_a_ready", 64'(a_req_ready), 64'd1);
        chk("rst_a_valid_busy", 64'({a_rsp_valid, a_busy}), 64'd0);
        chk("rst_a_outs", 64'({a_alu_op, a_rsp_flags, a_rsp_err, a_alu_x ^ a_rsp_z ^ a_alu_y}), 64'd0);
        chk("rst_b_ready_valid", 64'({b_req_ready, b_rsp_valid, b_busy}), 64'b100);
        step();
        step();
        n_rst = 1'b1;
        step();

        // ADD with signed overflow, latency check
        a_rsp_ready = 1'b1;
        push_a(32'h7FFFFFFF, 32'h00000001, 3'd1);
        chk("lat_c1_valid", 64'(a_rsp_valid), 64'd0);
        step();
        chk("lat_c2_valid", 64'(a_rsp_valid), 64'd0);
        chk("lat_c2_alu", 64'({a_alu_op, a_alu_x}), {29'd0, 3'd1, 32'h7FFFFFFF});
        step();
        chk("lat_c3_valid", 64'(a_rsp_valid), 64'd1);
        chk("add_ovf_z", 64'(a_rsp_z), 64'h80000000);
        chk("add_ovf_flags_err", 64'({a_rsp_flags, a_rsp_err}), 64'({3'b100, 1'b0}));
        step();
        chk("add_done_idle", 64'({a_rsp_valid, a_busy}), 64'd0);

        // SUB of equal operands
        push_a(32'h12345678, 32'h12345678, 3'd2);
        expect_rsp_a("sub_eq", 32'h0, 3'b011, 1'b0);
        step();

        // Backpressure and fill
        a_rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_req_x = fx[i]; a_req_y = fy[i]; a_req_op = fop[i]; a_req_valid = 1'b1;
            chk($sformatf("fill_ready_%0d", i), 64'(a_req_ready), (i < 5) ? 64'd1 : 64'd0);
            step();
        end
        a_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_%0d", i), 64'({a_rsp_valid, a_rsp_flags, a_rsp_z}), 64'({1'b1, 3'b000, 32'hF000F000}));
            step();
        end
        a_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_rsp_a($sformatf("drain_%0d", k), fz[k], ffl[k], 1'b0);
            step();
        end
        step();
        chk("drain_idle", 64'({a_busy, a_req_ready, a_rsp_valid}), 64'b010);
`ifdef ALU_REQ_STATS_EN
        chk("stat_ops_7", 64'(a_stat_ops), 64'd7);
        chk("stat_ovf_1", 64'(a_stat_ovf), 64'd1);
`endif

        // Reserved op, then a normal op clears rsp_err
        push_a(32'd5, 32'd5, 3'd7);
        expect_rsp_a("rsvd", 32'h0, 3'b000, 1'b1);
        step();
        push_a(32'd2, 32'd3, 3'd1);
        expect_rsp_a("after_rsvd", 32'd5, 3'b000, 1'b0);
        step();

        // SETTLE_CYCLES=3 on instance B
        b_req_x = 32'h10; b_req_y = 32'h20; b_req_op = 3'd1; b_req_valid = 1'b1;
        step();
        b_req_valid = 1'b0;
        chk("b_lat_c1", 64'(b_rsp_valid), 64'd0);
        step();
        chk("b_lat_c2", 64'({b_rsp_valid, b_alu_op, b_alu_x}), {28'd0, 1'b0, 3'd1, 32'h10});
        step();
        chk("b_lat_c3", 64'({b_rsp_valid, b_alu_op, b_alu_x}), {28'd0, 1'b0, 3'd1, 32'h10});
        step();
        chk("b_lat_c4", 64'({b_rsp_valid, b_alu_y}), {31'd0, 1'b0, 32'h20});
        step();
        chk("b_lat_c5", 64'({b_rsp_valid, b_rsp_err, b_rsp_flags, b_rsp_z}), {27'd0, 1'b1, 1'b0, 3'b000, 32'h30});
        step();
        chk("b_consumed", 64'(b_rsp_valid), 64'd0);

        // Reset while B is in WAIT with two requests queued
        for (int i = 0; i < 3; i++) begin
            b_req_x = 32'(i + 1); b_req_y = 32'd1; b_req_op = 3'd1; b_req_valid = 1'b1;
            step();
        end
        b_req_valid = 1'b0;
        chk("b_pre_rst_busy", 64'({b_busy, b_rsp_valid}), 64'b10);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_b_ctl", 64'({b_rsp_valid, b_busy, b_req_ready}), 64'b001);
        chk("mid_rst_b_alu", 64'(b_alu_x), 64'd0);
        chk("mid_rst_a_busy", 64'(a_busy), 64'd0);
`ifdef ALU_REQ_STATS_EN
        chk("mid_rst_stat_ops", 64'(a_stat_ops), 64'd0);
`endif
        #10 n_rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen = seen | b_rsp_valid | b_busy;
        end
        chk("no_rsp_after_rst", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
